// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: FSM states, AXI encodings and size helper shared by the core-to-AXI bridge.
package mem_axi_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [2:0] size_from_width(input int width);
    return 3'($clog2(width / 8));
  endfunction
endpackage

// File: rtl/mem_axi_bridge_if.sv
// mem_axi_bridge_if: core request/response and AXI4 master bus; master = bridge side, slave = core + memory side.
interface mem_axi_bridge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4
);
  logic                    io_req_valid, io_req_ready, io_req_bits_write;
  logic [ADDR_WIDTH-1:0]   io_req_bits_addr;
  logic [DATA_WIDTH-1:0]   io_req_bits_wdata;
  logic [DATA_WIDTH/8-1:0] io_req_bits_wstrb;
  logic                    io_resp_valid, io_resp_ready, io_resp_bits_err;
  logic [DATA_WIDTH-1:0]   io_resp_bits_rdata;
  logic                    io_m_axi_aw_valid, io_m_axi_aw_ready;
  logic [ID_WIDTH-1:0]     io_m_axi_aw_id;
  logic [ADDR_WIDTH-1:0]   io_m_axi_aw_addr;
  logic [7:0]              io_m_axi_aw_len;
  logic [2:0]              io_m_axi_aw_size;
  logic [1:0]              io_m_axi_aw_burst;
  logic                    io_m_axi_w_valid, io_m_axi_w_ready, io_m_axi_w_last;
  logic [DATA_WIDTH-1:0]   io_m_axi_w_data;
  logic [DATA_WIDTH/8-1:0] io_m_axi_w_strb;
  logic                    io_m_axi_b_valid, io_m_axi_b_ready;
  logic [ID_WIDTH-1:0]     io_m_axi_b_id;
  logic [1:0]              io_m_axi_b_resp;
  logic                    io_m_axi_ar_valid, io_m_axi_ar_ready;
  logic [ID_WIDTH-1:0]     io_m_axi_ar_id;
  logic [ADDR_WIDTH-1:0]   io_m_axi_ar_addr;
  logic [7:0]              io_m_axi_ar_len;
  logic [2:0]              io_m_axi_ar_size;
  logic [1:0]              io_m_axi_ar_burst;
  logic                    io_m_axi_r_valid, io_m_axi_r_ready, io_m_axi_r_last;
  logic [ID_WIDTH-1:0]     io_m_axi_r_id;
  logic [DATA_WIDTH-1:0]   io_m_axi_r_data;
  logic [1:0]              io_m_axi_r_resp;
  modport master (
    input  io_req_valid, io_req_bits_addr, io_req_bits_wdata, io_req_bits_wstrb, io_req_bits_write,
    output io_req_ready,
    output io_resp_valid, io_resp_bits_rdata, io_resp_bits_err,
    input  io_resp_ready,
    output io_m_axi_aw_valid, io_m_axi_aw_id, io_m_axi_aw_addr, io_m_axi_aw_len, io_m_axi_aw_size, io_m_axi_aw_burst,
    input  io_m_axi_aw_ready,
    output io_m_axi_w_valid, io_m_axi_w_data, io_m_axi_w_strb, io_m_axi_w_last,
    input  io_m_axi_w_ready,
    input  io_m_axi_b_valid, io_m_axi_b_id, io_m_axi_b_resp,
    output io_m_axi_b_ready,
    output io_m_axi_ar_valid, io_m_axi_ar_id, io_m_axi_ar_addr, io_m_axi_ar_len, io_m_axi_ar_size, io_m_axi_ar_burst,
    input  io_m_axi_ar_ready,
    input  io_m_axi_r_valid, io_m_axi_r_id, io_m_axi_r_data, io_m_axi_r_resp, io_m_axi_r_last,
    output io_m_axi_r_ready
  );
  modport slave (
    output io_req_valid, io_req_bits_addr, io_req_bits_wdata, io_req_bits_wstrb, io_req_bits_write,
    input  io_req_ready,
    input  io_resp_valid, io_resp_bits_rdata, io_resp_bits_err,
    output io_resp_ready,
    input  io_m_axi_aw_valid, io_m_axi_aw_id, io_m_axi_aw_addr, io_m_axi_aw_len, io_m_axi_aw_size, io_m_axi_aw_burst,
    output io_m_axi_aw_ready,
    input  io_m_axi_w_valid, io_m_axi_w_data, io_m_axi_w_strb, io_m_axi_w_last,
    output io_m_axi_w_ready,
    output io_m_axi_b_valid, io_m_axi_b_id, io_m_axi_b_resp,
    input  io_m_axi_b_ready,
    input  io_m_axi_ar_valid, io_m_axi_ar_id, io_m_axi_ar_addr, io_m_axi_ar_len, io_m_axi_ar_size, io_m_axi_ar_burst,
    output io_m_axi_ar_ready,
    output io_m_axi_r_valid, io_m_axi_r_id, io_m_axi_r_data, io_m_axi_r_resp, io_m_axi_r_last,
    input  io_m_axi_r_ready
  );
endinterface

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: one core request at a time to a single-beat AXI4 transaction.
// Define MEM_AXI_BRIDGE_ERR_EN to report non-OKAY responses / missing r_last on io_resp_bits_err.
module mem_axi_bridge
  import mem_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4
) (
  input logic clock,
  input logic reset,
  mem_axi_bridge_if.master bus
);
  localparam int OB = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] SIZE = size_from_width(DATA_WIDTH);
  state_t state;
  logic req_ready, resp_valid, aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic req_hs, resp_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  assign req_hs = bus.io_req_valid && req_ready;
  assign resp_hs = resp_valid && bus.io_resp_ready;
  assign aw_hs = aw_valid && bus.io_m_axi_aw_ready;
  assign w_hs = w_valid && bus.io_m_axi_w_ready;
  assign ar_hs = ar_valid && bus.io_m_axi_ar_ready;
  assign b_hs = b_ready && bus.io_m_axi_b_valid;
  assign r_hs = r_ready && bus.io_m_axi_r_valid;
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      aw_valid <= 1'b0;
      w_valid <= 1'b0;
      ar_valid <= 1'b0;
      b_ready <= 1'b0;
      r_ready <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !req_hs;
          if (req_hs) begin
            addr <= {bus.io_req_bits_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
            wdata <= bus.io_req_bits_wdata;
            wstrb <= bus.io_req_bits_wstrb;
            aw_valid <= bus.io_req_bits_write;
            w_valid <= bus.io_req_bits_write;
            ar_valid <= !bus.io_req_bits_write;
            state <= bus.io_req_bits_write ? WRITE : RADDR;
          end
        end
        WRITE: begin
          if (aw_hs) aw_valid <= 1'b0;
          if (w_hs) w_valid <= 1'b0;
          // AW and W complete independently; leave once neither is still pending
          if ((aw_hs || !aw_valid) && (w_hs || !w_valid)) begin
            b_ready <= 1'b1;
            state <= WRESP;
          end
        end
        WRESP:
          if (b_hs) begin
            b_ready <= 1'b0;
            rdata <= '0;
            resp_valid <= 1'b1;
            state <= RESP;
          end
        RADDR:
          if (ar_hs) begin
            ar_valid <= 1'b0;
            r_ready <= 1'b1;
            state <= RDATA;
          end
        RDATA:
          if (r_hs) begin
            r_ready <= 1'b0;
            rdata <= bus.io_m_axi_r_data;
            resp_valid <= 1'b1;
            state <= RESP;
          end
        RESP:
          if (resp_hs) begin
            resp_valid <= 1'b0;
            req_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef MEM_AXI_BRIDGE_ERR_EN
  logic err;
  always_ff @(posedge clock)
    if (!reset) err <= 1'b0;
    else if (b_hs) err <= bus.io_m_axi_b_resp != RESP_OKAY;
    else if (r_hs) err <= bus.io_m_axi_r_resp != RESP_OKAY || !bus.io_m_axi_r_last;
  assign bus.io_resp_bits_err = err;
  logic unused_ids;
  assign unused_ids = ^{bus.io_m_axi_b_id, bus.io_m_axi_r_id};
`else
  assign bus.io_resp_bits_err = 1'b0;
  logic unused_ids;
  assign unused_ids = ^{bus.io_m_axi_b_id, bus.io_m_axi_r_id, bus.io_m_axi_b_resp, bus.io_m_axi_r_resp, bus.io_m_axi_r_last};
`endif
  assign bus.io_req_ready = req_ready;
  assign bus.io_resp_valid = resp_valid;
  assign bus.io_resp_bits_rdata = rdata;
  assign bus.io_m_axi_aw_valid = aw_valid;
  assign bus.io_m_axi_aw_id = ID_WIDTH'(0);
  assign bus.io_m_axi_aw_addr = addr;
  assign bus.io_m_axi_aw_len = 8'd0;
  assign bus.io_m_axi_aw_size = SIZE;
  assign bus.io_m_axi_aw_burst = BURST_INCR;
  assign bus.io_m_axi_w_valid = w_valid;
  assign bus.io_m_axi_w_data = wdata;
  assign bus.io_m_axi_w_strb = wstrb;
  assign bus.io_m_axi_w_last = 1'b1;
  assign bus.io_m_axi_b_ready = b_ready;
  assign bus.io_m_axi_ar_valid = ar_valid;
  assign bus.io_m_axi_ar_id = ID_WIDTH'(0);
  assign bus.io_m_axi_ar_addr = addr;
  assign bus.io_m_axi_ar_len = 8'd0;
  assign bus.io_m_axi_ar_size = SIZE;
  assign bus.io_m_axi_ar_burst = BURST_INCR;
  assign bus.io_m_axi_r_ready = r_ready;
endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge: directed and randomized loads/stores against a transaction-level model of the bridge.
module tb_mem_axi_bridge;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  mem_axi_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();
  mem_axi_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [31:0] aligned(input logic [31:0] a);
    return a & ~32'(DW / 8 - 1);
  endfunction
  function automatic logic exp_err(input logic [1:0] resp, input logic last);
`ifdef MEM_AXI_BRIDGE_ERR_EN
    return resp != 2'b00 || !last;
`else
    return 1'b0;
`endif
  endfunction
  task automatic idle_inputs();
    bus.io_req_valid = 0;
    bus.io_req_bits_addr = '0;
    bus.io_req_bits_wdata = '0;
    bus.io_req_bits_wstrb = '0;
    bus.io_req_bits_write = 0;
    bus.io_resp_ready = 0;
    bus.io_m_axi_aw_ready = 0;
    bus.io_m_axi_w_ready = 0;
    bus.io_m_axi_b_valid = 0;
    bus.io_m_axi_b_id = '0;
    bus.io_m_axi_b_resp = '0;
    bus.io_m_axi_ar_ready = 0;
    bus.io_m_axi_r_valid = 0;
    bus.io_m_axi_r_id = '0;
    bus.io_m_axi_r_data = '0;
    bus.io_m_axi_r_resp = '0;
    bus.io_m_axi_r_last = 0;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_aw_valid"}, bus.io_m_axi_aw_valid, 0);
    check({tag, "_w_valid"}, bus.io_m_axi_w_valid, 0);
    check({tag, "_ar_valid"}, bus.io_m_axi_ar_valid, 0);
    check({tag, "_b_ready"}, bus.io_m_axi_b_ready, 0);
    check({tag, "_r_ready"}, bus.io_m_axi_r_ready, 0);
    check({tag, "_resp_valid"}, bus.io_resp_valid, 0);
  endtask
  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int n;
    bus.io_req_valid = 1;
    bus.io_req_bits_write = wr;
    bus.io_req_bits_addr = a;
    bus.io_req_bits_wdata = d;
    bus.io_req_bits_wstrb = s;
    n = 0;
    while (!bus.io_req_ready && n < 20) begin
      step();
      n++;
    end
    check("req_ready", bus.io_req_ready, 1);
    step();
    bus.io_req_valid = 0;
    check("req_ready_busy", bus.io_req_ready, 0);
  endtask
  task automatic resp_phase(input logic [63:0] rd_exp, input logic e, input int hold);
    repeat (hold) begin
      check("resp_hold_valid", bus.io_resp_valid, 1);
      check("resp_hold_rdata", bus.io_resp_bits_rdata, rd_exp);
      check("resp_hold_err", bus.io_resp_bits_err, e);
      check("resp_hold_req_ready", bus.io_req_ready, 0);
      step();
    end
    check("resp_valid", bus.io_resp_valid, 1);
    check("resp_rdata", bus.io_resp_bits_rdata, rd_exp);
    check("resp_err", bus.io_resp_bits_err, e);
    bus.io_resp_ready = 1;
    step();
    bus.io_resp_ready = 0;
    check("resp_done_valid", bus.io_resp_valid, 0);
    check("resp_done_req_ready", bus.io_req_ready, 1);
  endtask
  task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int awd, input int wd, input int bd, input logic [1:0] br, input int hold);
    logic aw_done, w_done, awv, wv, awr, wr;
    int n;
    issue(1, a, d, s);
    check("aw_valid_start", bus.io_m_axi_aw_valid, 1);
    check("w_valid_start", bus.io_m_axi_w_valid, 1);
    check("ar_valid_store", bus.io_m_axi_ar_valid, 0);
    check("aw_addr", bus.io_m_axi_aw_addr, aligned(a));
    check("aw_id", bus.io_m_axi_aw_id, 0);
    check("aw_len", bus.io_m_axi_aw_len, 0);
    check("aw_size", bus.io_m_axi_aw_size, 3);
    check("aw_burst", bus.io_m_axi_aw_burst, 1);
    check("w_data", bus.io_m_axi_w_data, d);
    check("w_strb", bus.io_m_axi_w_strb, s);
    check("w_last", bus.io_m_axi_w_last, 1);
    aw_done = 0;
    w_done = 0;
    n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      awr = n >= awd;
      wr = n >= wd;
      bus.io_m_axi_aw_ready = awr;
      bus.io_m_axi_w_ready = wr;
      awv = bus.io_m_axi_aw_valid;
      wv = bus.io_m_axi_w_valid;
      step();
      n++;
      if (awv && awr) aw_done = 1;
      if (wv && wr) w_done = 1;
      check("aw_valid", bus.io_m_axi_aw_valid, !aw_done);
      check("w_valid", bus.io_m_axi_w_valid, !w_done);
      check("b_ready", bus.io_m_axi_b_ready, aw_done && w_done);
    end
    check("write_phase_bound", aw_done && w_done, 1);
    bus.io_m_axi_aw_ready = 0;
    bus.io_m_axi_w_ready = 0;
    repeat (bd) begin
      check("b_wait_ready", bus.io_m_axi_b_ready, 1);
      check("b_wait_resp_valid", bus.io_resp_valid, 0);
      step();
    end
    bus.io_m_axi_b_valid = 1;
    bus.io_m_axi_b_resp = br;
    bus.io_m_axi_b_id = IW'($urandom);
    step();
    bus.io_m_axi_b_valid = 0;
    check("b_done_ready", bus.io_m_axi_b_ready, 0);
    resp_phase(64'd0, exp_err(br, 1'b1), hold);
  endtask
  task automatic do_load(input logic [31:0] a, input logic [63:0] d, input int ard, input int rdd,
                         input logic [1:0] rr, input logic rl, input int hold);
    issue(0, a, {$urandom, $urandom}, 8'($urandom));
    check("ar_valid_start", bus.io_m_axi_ar_valid, 1);
    check("aw_valid_load", bus.io_m_axi_aw_valid, 0);
    check("w_valid_load", bus.io_m_axi_w_valid, 0);
    check("ar_addr", bus.io_m_axi_ar_addr, aligned(a));
    check("ar_id", bus.io_m_axi_ar_id, 0);
    check("ar_len", bus.io_m_axi_ar_len, 0);
    check("ar_size", bus.io_m_axi_ar_size, 3);
    check("ar_burst", bus.io_m_axi_ar_burst, 1);
    repeat (ard) begin
      check("ar_wait_valid", bus.io_m_axi_ar_valid, 1);
      check("ar_wait_r_ready", bus.io_m_axi_r_ready, 0);
      step();
    end
    bus.io_m_axi_ar_ready = 1;
    step();
    bus.io_m_axi_ar_ready = 0;
    check("ar_done_valid", bus.io_m_axi_ar_valid, 0);
    repeat (rdd) begin
      check("r_wait_ready", bus.io_m_axi_r_ready, 1);
      check("r_wait_resp_valid", bus.io_resp_valid, 0);
      step();
    end
    check("r_ready", bus.io_m_axi_r_ready, 1);
    bus.io_m_axi_r_valid = 1;
    bus.io_m_axi_r_data = d;
    bus.io_m_axi_r_resp = rr;
    bus.io_m_axi_r_last = rl;
    bus.io_m_axi_r_id = IW'($urandom);
    step();
    bus.io_m_axi_r_valid = 0;
    bus.io_m_axi_r_data = {$urandom, $urandom};
    check("r_done_ready", bus.io_m_axi_r_ready, 0);
    resp_phase(d, exp_err(rr, rl), hold);
  endtask
  initial begin
    idle_inputs();
    reset = 0;
    repeat (3) step();
    check_quiet("reset");
    check("reset_req_ready", bus.io_req_ready, 0);
    check("reset_aw_addr", bus.io_m_axi_aw_addr, 0);
    check("reset_rdata", bus.io_resp_bits_rdata, 0);
    check("reset_aw_size", bus.io_m_axi_aw_size, 3);
    check("reset_ar_burst", bus.io_m_axi_ar_burst, 1);
    reset = 1;
    step();
    check("post_reset_req_ready", bus.io_req_ready, 1);
    do_store(32'h08, 64'hDEADBEEF, 8'h0F, 0, 0, 0, 2'b00, 0);
    do_load(32'h08, 64'hDEADBEEF, 0, 0, 2'b00, 1'b1, 0);
    do_store(32'h40, 64'h0123_4567_89AB_CDEF, 8'hF0, 3, 0, 0, 2'b00, 0);
    do_store(32'h0C, 64'h1111_2222_3333_4444, 8'hFF, 0, 2, 1, 2'b00, 5);
    do_store(32'h100, 64'h55AA, 8'h03, 0, 0, 0, 2'b10, 1);
    do_load(32'h204, 64'hCAFE_F00D_0000_0001, 1, 2, 2'b00, 1'b0, 2);
    do_load(32'h300, 64'hFFFF_0000_FFFF_0000, 0, 0, 2'b11, 1'b1, 0);
    issue(0, 32'h18, 64'd0, 8'h00);
    bus.io_m_axi_ar_ready = 1;
    step();
    bus.io_m_axi_ar_ready = 0;
    check("mid_reset_in_rdata", bus.io_m_axi_r_ready, 1);
    reset = 0;
    step();
    reset = 1;
    check_quiet("mid_reset");
    check("mid_reset_req_ready", bus.io_req_ready, 0);
    bus.io_m_axi_r_valid = 1;
    bus.io_m_axi_r_data = 64'hBAD;
    bus.io_m_axi_r_last = 1;
    step();
    bus.io_m_axi_r_valid = 0;
    check("after_reset_resp_valid", bus.io_resp_valid, 0);
    check("after_reset_req_ready", bus.io_req_ready, 1);
    do_load(32'h18, 64'h7777_8888_9999_AAAA, 0, 0, 2'b00, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      a = $urandom;
      d = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1)
        do_store(a, d, 8'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0),
                 2'($urandom), $urandom_range(3, 0));
      else
        do_load(a, d, $urandom_range(3, 0), $urandom_range(3, 0), 2'($urandom),
                $urandom_range(3, 0) != 0, $urandom_range(3, 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
